addr_stack_feeder: RTL and testbench

Upstream command generator for the physical neuron controller's 3-entry address stack. It accepts address request words from the spike/route decoder over a valid/ready handshake and buffers them in a small FIFO. It converts each word into the stack's 2-bit control code plus data word, and tracks stack occupancy locally so the stack never overflows. When no requests are pending it drains the stack.

---
 rtl/addr_stack_feeder_pkg.sv | 26 ++
 rtl/addr_stack_feeder_req_fifo.sv | 80 ++++++++
 rtl/addr_stack_feeder.sv | 132 +++++++++++++
 tb/tb_addr_stack_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_stack_feeder_pkg.sv
// ---------------------------------------------------------------------------
// addr_stack_feeder_pkg
// Shared definitions for the address stack feeder:
//   - stack_ctl_e : 2-bit command codes understood by the 3-entry address
//                   stack (2'b10 is reserved and never issued)
//   - STACK_SIZE  : default depth of the downstream stack
//   - OCC_W       : width of the occupancy mirror
//   - tag_lsb()   : bit position of the 4-bit core tag in a request word
// ---------------------------------------------------------------------------
package addr_stack_feeder_pkg;

    typedef enum logic [1:0] {
        CTL_POP    = 2'b00,
        CTL_SINGLE = 2'b01,
        CTL_PAIR   = 2'b11
    } stack_ctl_e;

    localparam int STACK_SIZE = 3;
    localparam int OCC_W      = 2;

    // The core tag occupies the top four bits of the request word.
    function automatic int tag_lsb(input int data_width);
        return data_width - 4;
    endfunction

endpackage : addr_stack_feeder_pkg

// File: rtl/addr_stack_feeder_req_fifo.sv
// ---------------------------------------------------------------------------
// req_fifo
// Generic synchronous FIFO with registered full/empty flags.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// Reads are first-word-fall-through from the register array; a word written
// into an empty FIFO becomes visible at rd_data one cycle later because
// empty is registered (no bypass).
// Ports:
//   clk, rst         : clock, synchronous active-high reset (flushes)
//   wr_en, wr_data   : write request; ignored while full
//   rd_en            : pop request; ignored while empty
//   rd_data          : current head entry
//   full, empty      : registered status flags
// ---------------------------------------------------------------------------
module req_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    assign do_wr = wr_en && !full_q;
    assign do_rd = rd_en && !empty_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        // Same index with differing wrap bits means the writer lapped the reader.
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        empty_d = (wptr_d == rptr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule : req_fifo

// File: rtl/addr_stack_feeder.sv
// ---------------------------------------------------------------------------
// addr_stack_feeder
// Command generator for the neuron controller's address stack. Request words
// are buffered in a small FIFO and turned into one stack command per clock.
// A local occupancy mirror keeps the stack from overflowing; when no request
// is pending the stack is drained one entry per cycle.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready = FIFO not full)
//   req_pair, req_data   : request: pair flag and data word
//   stack_ctl/stack_data : registered stack command and data
//   stack_wait           : stack full indication (should never assert)
//   addr_valid           : stack output carries a fresh address this cycle
//   occ                  : mirrored stack occupancy
//   busy                 : FIFO non-empty or stack non-empty
//   err_overflow         : sticky, set when stack_wait is seen
// ---------------------------------------------------------------------------
module addr_stack_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STACK_SIZE = addr_stack_feeder_pkg::STACK_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_pair,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic [1:0]            stack_ctl,
    output logic [DATA_WIDTH-1:0] stack_data,
    input  logic                  stack_wait,
    output logic                  addr_valid,
    output logic [1:0]            occ,
    output logic                  busy,
    output logic                  err_overflow
);

    import addr_stack_feeder_pkg::*;

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(STACK_SIZE);

    // FIFO entry layout: {pair flag, data word}
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  head_pair;
    logic [DATA_WIDTH-1:0] head_data;

    req_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (req_valid),
        .wr_data ({req_pair, req_data}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_pair = fifo_head[DATA_WIDTH];
    assign head_data = fifo_head[DATA_WIDTH-1:0];

    stack_ctl_e            stack_ctl_q, stack_ctl_d;
    logic [DATA_WIDTH-1:0] stack_data_q, stack_data_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  av_pend_q, av_pend_d;   // command just registered yields an address
    logic                  addr_valid_q;
    logic                  err_q, err_d;

    // Issue decision, highest priority first.
    always_comb begin
        stack_ctl_d  = CTL_POP;
        stack_data_d = '0;
        occ_d        = occ_q;
        av_pend_d    = 1'b0;
        fifo_pop     = 1'b0;
        err_d        = err_q | stack_wait;

        if (stack_wait || fifo_empty || (head_pair && occ_q == OCC_MAX)) begin
            // Drain one entry (or idle when the stack is empty). A stack_wait
            // forces this path so nothing new is pushed onto a full stack.
            if (occ_q != '0) begin
                occ_d     = occ_q - 1'b1;
                av_pend_d = 1'b1;
            end
        end else if (!head_pair) begin
            stack_ctl_d  = CTL_SINGLE;
            stack_data_d = head_data;
            av_pend_d    = 1'b1;
            fifo_pop     = 1'b1;
        end else begin
            // Pair: one address goes straight out, the other is pushed.
            stack_ctl_d  = CTL_PAIR;
            stack_data_d = head_data;
            occ_d        = occ_q + 1'b1;
            av_pend_d    = 1'b1;
            fifo_pop     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stack_ctl_q  <= CTL_POP;
            stack_data_q <= '0;
            occ_q        <= '0;
            av_pend_q    <= 1'b0;
            addr_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            stack_ctl_q  <= stack_ctl_d;
            stack_data_q <= stack_data_d;
            occ_q        <= occ_d;
            av_pend_q    <= av_pend_d;
            // The stack presents its address one cycle after the command.
            addr_valid_q <= av_pend_q;
            err_q        <= err_d;
        end
    end

    assign req_ready    = !fifo_full;
    assign stack_ctl    = stack_ctl_q;
    assign stack_data   = stack_data_q;
    assign addr_valid   = addr_valid_q;
    assign occ          = occ_q;
    assign busy         = !fifo_empty || (occ_q != '0);
    assign err_overflow = err_q;

endmodule : addr_stack_feeder

// File: tb/tb_addr_stack_feeder.sv
// ---------------------------------------------------------------------------
// tb_addr_stack_feeder
// Directed self-checking bench for addr_stack_feeder. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_addr_stack_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_pair;
    logic [15:0] req_data;
    logic [1:0]  stack_ctl;
    logic [15:0] stack_data;
    logic        stack_wait;
    logic        addr_valid;
    logic [1:0]  occ;
    logic        busy;
    logic        err_overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int av_count = 0;

    always #5 clk = ~clk;

    addr_stack_feeder #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .STACK_SIZE (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pair     (req_pair),
        .req_data     (req_data),
        .stack_ctl    (stack_ctl),
        .stack_data   (stack_data),
        .stack_wait   (stack_wait),
        .addr_valid   (addr_valid),
        .occ          (occ),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    // Running count of address pulses seen at the stack output.
    always @(posedge clk) begin
        if (rst) av_count <= 0;
        else if (addr_valid) av_count <= av_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [1:0] ctl, input logic [15:0] data,
                             input logic [1:0] o);
        check({tag, ".ctl"},  32'(stack_ctl),  32'(ctl));
        check({tag, ".data"}, 32'(stack_data), 32'(data));
        check({tag, ".occ"},  32'(occ),        32'(o));
    endtask

    task automatic drive(input logic v, input logic p, input logic [15:0] d);
        req_valid = v;
        req_pair  = p;
        req_data  = d;
    endtask

    int base;
    int idx;
    int guard;
    logic ready_low_seen;

    initial begin
        rst = 1'b1;
        stack_wait = 1'b0;
        drive(1'b0, 1'b0, 16'h0);

        // ---------------- reset and idle ----------------
        tick(); tick();
        check("rst.ctl", 32'(stack_ctl), 32'h0);
        check("rst.ready", 32'(req_ready), 32'h1);
        check("rst.err", 32'(err_overflow), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle%0d.ctl", i), 32'(stack_ctl), 32'h0);
            check($sformatf("idle%0d.av", i), 32'(addr_valid), 32'h0);
            check($sformatf("idle%0d.occ", i), 32'(occ), 32'h0);
            check($sformatf("idle%0d.ready", i), 32'(req_ready), 32'h1);
            check($sformatf("idle%0d.busy", i), 32'(busy), 32'h0);
        end

        // ---------------- single request ----------------
        drive(1'b1, 1'b0, 16'h3012);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        check("single.wr.ctl", 32'(stack_ctl), 32'h0);
        check("single.wr.busy", 32'(busy), 32'h1);
        tick();
        check_cmd("single.iss", 2'b01, 16'h3012, 2'd0);
        check("single.iss.av", 32'(addr_valid), 32'h0);
        tick();
        check("single.av", 32'(addr_valid), 32'h1);
        check_cmd("single.after", 2'b00, 16'h0, 2'd0);
        tick();
        check("single.av_off", 32'(addr_valid), 32'h0);
        tick(); tick();

        // ---------------- four back-to-back pairs ----------------
        base = av_count;
        drive(1'b1, 1'b1, 16'h5A21);
        tick();
        drive(1'b1, 1'b1, 16'h5A22);
        tick();
        check_cmd("pair4.c1", 2'b11, 16'h5A21, 2'd1);
        drive(1'b1, 1'b1, 16'h5A23);
        tick();
        check_cmd("pair4.c2", 2'b11, 16'h5A22, 2'd2);
        drive(1'b1, 1'b1, 16'h5A24);
        tick();
        check_cmd("pair4.c3", 2'b11, 16'h5A23, 2'd3);
        drive(1'b0, 1'b0, 16'h0);
        tick();
        check_cmd("pair4.c4", 2'b00, 16'h0, 2'd2);
        tick();
        check_cmd("pair4.c5", 2'b11, 16'h5A24, 2'd3);
        tick(); tick(); tick();
        check_cmd("pair4.drained", 2'b00, 16'h0, 2'd0);
        tick(); tick(); tick();
        check("pair4.pulses", 32'(av_count - base), 32'd8);
        check("pair4.err", 32'(err_overflow), 32'h0);

        // ---------------- FIFO fill under pair pressure ----------------
        base = av_count;
        ready_low_seen = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 10 && guard < 100) begin
            drive(1'b1, 1'b1, 16'h6000 + 16'(idx));
            if (!req_ready) ready_low_seen = 1'b1;
            if (req_ready) idx++;
            tick();
            guard++;
        end
        drive(1'b0, 1'b0, 16'h0);
        check("fill.accepted", 32'(idx), 32'd10);
        check("fill.ready_dropped", 32'(ready_low_seen), 32'h1);
        for (int i = 0; i < 40; i++) tick();
        check("fill.pulses", 32'(av_count - base), 32'd20);
        check("fill.occ", 32'(occ), 32'h0);
        check("fill.busy", 32'(busy), 32'h0);
        check("fill.err", 32'(err_overflow), 32'h0);

        // ---------------- mixed single/pair/single ----------------
        base = av_count;
        drive(1'b1, 1'b0, 16'h1101);
        tick();
        drive(1'b1, 1'b1, 16'h2202);
        tick();
        check_cmd("mix.c1", 2'b01, 16'h1101, 2'd0);
        drive(1'b1, 1'b0, 16'h3303);
        tick();
        check_cmd("mix.c2", 2'b11, 16'h2202, 2'd1);
        drive(1'b0, 1'b0, 16'h0);
        tick();
        check_cmd("mix.c3", 2'b01, 16'h3303, 2'd1);
        tick();
        check_cmd("mix.c4", 2'b00, 16'h0, 2'd0);
        tick();
        check_cmd("mix.c5", 2'b00, 16'h0, 2'd0);
        check("mix.c4_av", 32'(addr_valid), 32'h1);
        tick();
        check("mix.c5_no_av", 32'(addr_valid), 32'h0);
        check("mix.pulses", 32'(av_count - base), 32'd4);
        tick();

        // ---------------- stack_wait with occ=2 ----------------
        drive(1'b1, 1'b1, 16'h4401);
        tick();
        drive(1'b1, 1'b1, 16'h4402);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        tick();
        check_cmd("wait.pre", 2'b11, 16'h4402, 2'd2);
        check("wait.pre_err", 32'(err_overflow), 32'h0);
        stack_wait = 1'b1;
        tick();
        stack_wait = 1'b0;
        check_cmd("wait.forced", 2'b00, 16'h0, 2'd1);
        check("wait.err", 32'(err_overflow), 32'h1);
        tick();
        check("wait.occ0", 32'(occ), 32'h0);
        // Forced idle must hold back a pending single.
        drive(1'b1, 1'b0, 16'h5501);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        stack_wait = 1'b1;
        tick();
        stack_wait = 1'b0;
        check_cmd("wait.hold", 2'b00, 16'h0, 2'd0);
        check("wait.hold_busy", 32'(busy), 32'h1);
        tick();
        check_cmd("wait.release", 2'b01, 16'h5501, 2'd0);
        tick();
        check("wait.release_av", 32'(addr_valid), 32'h1);
        check("wait.sticky", 32'(err_overflow), 32'h1);
        tick(); tick();

        // ---------------- reset mid-burst (FIFO 3 entries, occ 2) ----------------
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 16'h7700 + 16'(i));
            tick();
        end
        check("burst.occ", 32'(occ), 32'd2);
        check("burst.busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        check_cmd("burst.rst", 2'b00, 16'h0, 2'd0);
        check("burst.rst_av", 32'(addr_valid), 32'h0);
        check("burst.rst_err", 32'(err_overflow), 32'h0);
        check("burst.rst_ready", 32'(req_ready), 32'h1);
        check("burst.rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        tick();
        check("post.idle_ctl", 32'(stack_ctl), 32'h0);
        check("post.idle_busy", 32'(busy), 32'h0);
        drive(1'b1, 1'b0, 16'h3012);
        tick();
        drive(1'b0, 1'b0, 16'h0);
        tick();
        check_cmd("post.single", 2'b01, 16'h3012, 2'd0);
        tick();
        check("post.single_av", 32'(addr_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_addr_stack_feeder
